// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and fill-factor width helper for the PWM block family.
// Revision 1.0
`default_nettype none

package pwm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_RAMP_UP   = 2'd1;
  localparam state_t ST_RAMP_DOWN = 2'd2;

  // Width of a fill-factor bus; a degenerate maximum still gets one bit.
  function automatic int fill_w(input int max_fill);
    return (max_fill < 2) ? 1 : $clog2(max_fill);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_fill_ramp_if.sv
// pwm_fill_ramp_if: target handshake bundle (IMMEDIATE present with PWM_FILL_RAMP_IMMEDIATE_EN).
// Revision 1.0
`default_nettype none

interface pwm_fill_ramp_if #(
  parameter int TGT_W = 3
);

  logic [TGT_W-1:0] tgt;
  logic             tgt_valid;
  logic             tgt_ready;
`ifdef PWM_FILL_RAMP_IMMEDIATE_EN
  logic             immediate;

  modport master (output tgt, output tgt_valid, output immediate, input tgt_ready);
  modport slave  (input tgt, input tgt_valid, input immediate, output tgt_ready);
`else
  modport master (output tgt, output tgt_valid, input tgt_ready);
  modport slave  (input tgt, input tgt_valid, output tgt_ready);
`endif

endinterface

`default_nettype wire

// File: rtl/pwm_tick_div.sv
// pwm_tick_div: CE-qualified modulo-DIV counter emitting a tick on the wrap cycle.
// Revision 1.0
`default_nettype none

module pwm_tick_div #(
  parameter int DIV = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic ce_i,
  input  wire logic sync_clr_i,
  output logic      tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr_i) begin
      cnt_d = '0;
    end else if (ce_i) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = ce_i & (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_fill_ramp.sv
// pwm_fill_ramp: slew-limited fill-factor driver for a PWM channel; optional PWM_FILL_RAMP_IMMEDIATE_EN.
// Revision 1.0
`default_nettype none

module pwm_fill_ramp
  import pwm_pkg::*;
#(
  parameter int FILL_FACTOR_MAX = 7,
  parameter int STEP            = 1,
  parameter int RAMP_DIV        = 4,
  parameter int INIT_FILL       = 0,
  parameter int TGT_W           = fill_w(FILL_FACTOR_MAX)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              ce_i,
  pwm_fill_ramp_if.slave         tgt_if,
  output logic [fill_w(FILL_FACTOR_MAX)-1:0] fill_factor_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int W = fill_w(FILL_FACTOR_MAX);
  localparam logic [W:0]   C_STEP_X = (W + 1)'(STEP);
  localparam logic [W-1:0] C_STEP   = W'(STEP);
  localparam logic [W-1:0] C_MAX    = W'(FILL_FACTOR_MAX);
  localparam logic [W-1:0] C_INIT   = W'(INIT_FILL);

  state_t         state_q, state_d;
  logic [W-1:0]   fill_q, fill_d;
  logic [W-1:0]   tgt_q, tgt_d;
  logic           done_q, done_d;
  logic           rdy_en_q;

  logic [W-1:0]   tgt_clamp;
  logic           accept;
  logic           imm;
  logic           tick;
  logic [W:0]     up_sum;
  logic [W:0]     dn_lim;
  logic [W-1:0]   step_up;
  logic [W-1:0]   step_dn;

`ifdef PWM_FILL_RAMP_IMMEDIATE_EN
  assign imm = tgt_if.immediate;
`else
  assign imm = 1'b0;
`endif

  always_comb begin
    tgt_clamp = W'(tgt_if.tgt);
    if (32'(tgt_if.tgt) > FILL_FACTOR_MAX) begin
      tgt_clamp = C_MAX;
    end
  end

  assign accept = (state_q == ST_IDLE) & rdy_en_q & tgt_if.tgt_valid;

  // Both directions saturate at the captured target, so no overshoot or wrap.
  assign up_sum  = {1'b0, fill_q} + C_STEP_X;
  assign dn_lim  = {1'b0, tgt_q} + C_STEP_X;
  assign step_up = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[W-1:0];
  assign step_dn = ({1'b0, fill_q} < dn_lim) ? tgt_q : fill_q - C_STEP;

  pwm_tick_div #(
    .DIV (RAMP_DIV)
  ) u_tick_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce_i       (ce_i & (state_q != ST_IDLE)),
    .sync_clr_i (accept),
    .tick_o     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fill_q   <= C_INIT;
      tgt_q    <= C_INIT;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      tgt_q    <= tgt_d;
      done_q   <= done_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !imm) begin
          if (tgt_clamp > fill_q) begin
            state_d = ST_RAMP_UP;
          end else if (tgt_clamp < fill_q) begin
            state_d = ST_RAMP_DOWN;
          end
        end
      end
      ST_RAMP_UP: begin
        if (tick && (step_up == tgt_q)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP_DOWN: begin
        if (tick && (step_dn == tgt_q)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    tgt_d  = tgt_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_d = tgt_clamp;
          if (imm) begin
            fill_d = tgt_clamp;
            done_d = 1'b1;
          end else if (tgt_clamp == fill_q) begin
            done_d = 1'b1;
          end
        end
      end
      ST_RAMP_UP: begin
        if (tick) begin
          fill_d = step_up;
          done_d = (step_up == tgt_q);
        end
      end
      ST_RAMP_DOWN: begin
        if (tick) begin
          fill_d = step_dn;
          done_d = (step_dn == tgt_q);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o           = (state_q != ST_IDLE);
    tgt_if.tgt_ready = rdy_en_q & (state_q == ST_IDLE);
    fill_factor_o    = fill_q;
    done_o           = done_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_fill_ramp.sv
// tb_pwm_fill_ramp: two ramps (STEP=1 and STEP=2) against a step-schedule model, plus pinned literals.
// Revision 1.0
`default_nettype none

module tb_pwm_fill_ramp;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [3:0] tgt;
  logic       valid;
  logic       imm;
  logic [2:0] fill_a, fill_b;
  logic       busy_a, busy_b, done_a, done_b;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  pwm_fill_ramp_if #(.TGT_W(4)) if_a ();
  pwm_fill_ramp_if #(.TGT_W(4)) if_b ();

  assign if_a.tgt       = tgt;
  assign if_a.tgt_valid = valid;
  assign if_b.tgt       = tgt;
  assign if_b.tgt_valid = valid;
`ifdef PWM_FILL_RAMP_IMMEDIATE_EN
  assign if_a.immediate = imm;
  assign if_b.immediate = imm;
`endif

  pwm_fill_ramp #(.FILL_FACTOR_MAX(7), .STEP(1), .RAMP_DIV(DIV), .INIT_FILL(0), .TGT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .ce_i(ce), .tgt_if(if_a.slave),
    .fill_factor_o(fill_a), .busy_o(busy_a), .done_o(done_a)
  );

  pwm_fill_ramp #(.FILL_FACTOR_MAX(7), .STEP(2), .RAMP_DIV(DIV), .INIT_FILL(0), .TGT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .ce_i(ce), .tgt_if(if_b.slave),
    .fill_factor_o(fill_b), .busy_o(busy_b), .done_o(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: on accept, precompute every value the output must take; one value
  // is released each DIV-th CE-qualified edge after the accept.
  int seq [2][16];
  int slen [2];
  int spos [2];
  int cecnt [2];
  int mfill [2];
  bit mdone [2];
  bit mrdy_en;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      slen[i] = 0; spos[i] = 0; cecnt[i] = 0; mfill[i] = 0; mdone[i] = 0;
    end
    mrdy_en = 0;
  endtask

  task automatic model_edge(input int i);
    int s;
    int t;
    int v;
    s = (i == 0) ? 1 : 2;
    mdone[i] = 0;
    if (spos[i] < slen[i]) begin
      if (ce) begin
        cecnt[i]++;
        if (cecnt[i] == DIV) begin
          cecnt[i] = 0;
          mfill[i] = seq[i][spos[i]];
          spos[i]++;
          if (spos[i] == slen[i]) mdone[i] = 1;
        end
      end
    end else if (mrdy_en && valid) begin
      t = (int'(tgt) > 7) ? 7 : int'(tgt);
      cecnt[i] = 0; slen[i] = 0; spos[i] = 0;
      if (imm) begin
        mfill[i] = t;
        mdone[i] = 1;
      end else if (t == mfill[i]) begin
        mdone[i] = 1;
      end else begin
        v = mfill[i];
        while (v != t) begin
          if (t > v) v = (v + s > t) ? t : v + s;
          else       v = (v - s < t) ? t : v - s;
          seq[i][slen[i]] = v;
          slen[i]++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        model_edge(0);
        model_edge(1);
        mrdy_en = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmp_fill_a",  32'(fill_a), 32'(mfill[0]));
        chk("cmp_busy_a",  32'(busy_a), 32'(spos[0] < slen[0]));
        chk("cmp_done_a",  32'(done_a), 32'(mdone[0]));
        chk("cmp_ready_a", 32'(if_a.tgt_ready), 32'(mrdy_en && !(spos[0] < slen[0])));
        chk("cmp_fill_b",  32'(fill_b), 32'(mfill[1]));
        chk("cmp_busy_b",  32'(busy_b), 32'(spos[1] < slen[1]));
        chk("cmp_done_b",  32'(done_b), 32'(mdone[1]));
        chk("cmp_ready_b", 32'(if_b.tgt_ready), 32'(mrdy_en && !(spos[1] < slen[1])));
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle valid; returns at the negedge right after the accept edge.
  task automatic accept(input int t);
    tgt   = 4'(t);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; ce = 1'b1; valid = 1'b0; tgt = '0; imm = 1'b0;
    #1 rst_n = 1'b0;
    chk_en = 1;
    wait_n(10);
    chk("rst_ready_low", 32'(if_a.tgt_ready), 32'd0);
    rst_n = 1'b1;
    wait_n(1);
    chk("rst_ready_high", 32'(if_a.tgt_ready), 32'd1);
    chk("rst_fill", 32'(fill_a), 32'd0);
    chk("rst_busy_done", 32'({busy_a, done_a}), 32'd0);

    // Ramp up to 3.
    accept(3);
    chk("up_busy", 32'({busy_a, busy_b}), 32'd3);
    wait_n(3);
    chk("up_k3", 32'(fill_a), 32'd0);
    wait_n(1);
    chk("up_k4_a", 32'(fill_a), 32'd1);
    chk("up_k4_b", 32'(fill_b), 32'd2);
    tgt = 4'd5; valid = 1'b1;
    wait_n(2);
    chk("ramp_ready_low", 32'(if_a.tgt_ready), 32'd0);
    valid = 1'b0;
    wait_n(2);
    chk("up_k8_a", 32'(fill_a), 32'd2);
    chk("up_k8_b", 32'({fill_b, done_b, busy_b}), 32'({3'd3, 1'b1, 1'b0}));
    wait_n(4);
    chk("up_k12_a", 32'({fill_a, done_a, busy_a}), 32'({3'd3, 1'b1, 1'b0}));
    wait_n(4);
    chk("ignored_tgt", 32'({fill_a, done_a}), 32'({3'd3, 1'b0}));

    // Clamp 15 -> 7.
    accept(15);
    wait_n(16);
    chk("clamp_a", 32'({fill_a, done_a}), 32'({3'd7, 1'b1}));
    chk("clamp_b", 32'(fill_b), 32'd7);

    // Ramp down to 2; STEP=2 goes 5,3,2.
    accept(2);
    wait_n(4);
    chk("dn_k4_b", 32'(fill_b), 32'd5);
    chk("dn_k4_a", 32'(fill_a), 32'd6);
    wait_n(4);
    chk("dn_k8_b", 32'(fill_b), 32'd3);
    wait_n(4);
    chk("dn_k12_b", 32'({fill_b, done_b}), 32'({3'd2, 1'b1}));
    wait_n(8);
    chk("dn_k20_a", 32'({fill_a, done_a}), 32'({3'd2, 1'b1}));

    // Equal target.
    accept(2);
    chk("eq_done", 32'({done_a, done_b, busy_a, busy_b}), 32'b1100);

    // CE gated for 6 cycles mid-ramp.
    accept(6);
    wait_n(2);
    ce = 1'b0;
    wait_n(6);
    ce = 1'b1;
    wait_n(1);
    chk("ce_hold_a", 32'(fill_a), 32'd2);
    wait_n(1);
    chk("ce_step_a", 32'(fill_a), 32'd3);
    chk("ce_step_b", 32'(fill_b), 32'd4);
    wait_n(12);
    chk("ce_end_a", 32'({fill_a, done_a}), 32'({3'd6, 1'b1}));

    // Async reset mid-ramp at fill 2.
    accept(0);
    wait_n(16);
    chk("mid_fill_a", 32'({fill_a, busy_a}), 32'({3'd2, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fill", 32'({fill_a, fill_b}), 32'd0);
    chk("arst_flags", 32'({busy_a, busy_b, done_a, done_b, if_a.tgt_ready}), 32'd0);
    wait_n(1);
    rst_n = 1'b1;
    wait_n(1);
    chk("arst_release", 32'({if_a.tgt_ready, done_a, busy_a}), 32'b100);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      ce    = ($urandom % 8) != 0;
      valid = ($urandom % 3) == 0;
      tgt   = 4'($urandom_range(0, 15));
`ifdef PWM_FILL_RAMP_IMMEDIATE_EN
      imm   = ($urandom % 4) == 0;
`endif
      if (($urandom % 700) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
    valid = 1'b0; ce = 1'b1; imm = 1'b0;

`ifdef PWM_FILL_RAMP_IMMEDIATE_EN
    begin
      int n;
      n = 0;
      while ((busy_a || busy_b) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("imm_idle_wait", 32'(busy_a || busy_b), 32'd0);
      imm = 1'b1;
      accept(6);
      imm = 1'b0;
      chk("imm_fill", 32'({fill_a, fill_b}), 32'({3'd6, 3'd6}));
      chk("imm_flags", 32'({done_a, busy_a, done_b, busy_b}), 32'b1010);
    end
`endif

    wait_n(2);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_fill_ramp.md
Name: pwm_fill_ramp

Overview:
- Soft-start / slew-rate limiter that sits directly upstream of the PWM channel and drives its FILL_FACTOR input.
- Accepts a target fill factor through a valid/ready handshake.
- Steps its FILL_FACTOR output toward the target by STEP once every RAMP_DIV enabled clock ticks, so load current never sees a duty jump larger than STEP.
- Shares CLK and CE with the downstream PWM channel.

Parameters:
- FILL_FACTOR_MAX, 7: maximum fill factor; W = $clog2(FILL_FACTOR_MAX) is the fill-factor width, identical to the PWM channel's FILL_FACTOR port.
- STEP, 1: fill-factor increment per ramp tick; range 1..FILL_FACTOR_MAX.
- RAMP_DIV, 4: CE-qualified clock ticks per ramp step; must be ≥1.
- INIT_FILL, 0: FILL_FACTOR value after reset; must be ≤ FILL_FACTOR_MAX.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable; the ramp prescaler advances only when CE=1.
- TGT  in  W  requested fill factor.
- TGT_VALID  in  1  TGT is valid.
- TGT_READY  out  1  block can accept a target.
- FILL_FACTOR  out  W  registered fill factor to the PWM channel.
- BUSY  out  1  ramp in progress.
- DONE  out  1  one-cycle pulse when FILL_FACTOR reaches the accepted target.

Behaviour:
- Reset (CLR=0, async):
  - FILL_FACTOR=INIT_FILL; target register=INIT_FILL; prescaler cnt=0.
  - State=IDLE; BUSY=0; DONE=0; TGT_READY=0 while CLR=0, then 1 from the first cycle after release.
- Targets:
  - An accepted TGT above FILL_FACTOR_MAX is clamped to FILL_FACTOR_MAX on capture.
- FSM states IDLE, RAMP_UP, RAMP_DOWN; encoding 2 bits:
  - IDLE: TGT_READY=1, BUSY=0.
    - Accept happens on the edge where TGT_VALID & TGT_READY.
    - On accept: capture clamped target, set cnt=0.
    - Target > FILL_FACTOR → RAMP_UP. Target < FILL_FACTOR → RAMP_DOWN.
    - Target == FILL_FACTOR → stay IDLE; DONE=1 for the following cycle.
  - RAMP_UP / RAMP_DOWN: TGT_READY=0, BUSY=1.
    - TGT_VALID is ignored in these states; a new target is accepted only after return to IDLE.
- Prescaler:
  - In a RAMP state, on each edge with CE=1: if cnt==RAMP_DIV-1 then step tick and cnt=0, else cnt+1.
  - CE=0 freezes cnt and FILL_FACTOR.
  - Step tick timing: if accept is at edge k and CE=1 throughout, steps occur at edges k+RAMP_DIV, k+2·RAMP_DIV, …
- Step arithmetic:
  - Computed in W+1 bits.
  - Up: FILL_FACTOR = min(FILL_FACTOR+STEP, target).
  - Down: FILL_FACTOR = (FILL_FACTOR < target+STEP) ? target : FILL_FACTOR-STEP.
  - Never overshoots the target, never wraps below 0 or above FILL_FACTOR_MAX.
- Completion:
  - On the step edge where FILL_FACTOR becomes target: state→IDLE, BUSY→0, DONE=1 for exactly that next cycle, TGT_READY→1.
  - DONE and TGT_READY are both high in that cycle; a back-to-back accept there is legal.
- Latency: outputs are registered, with no combinational path from TGT/TGT_VALID to any output except through state.
- Reset mid-ramp: all state returns to reset values immediately; no DONE is issued.

Optional Feature:
- Macro PWM_FILL_RAMP_IMMEDIATE_EN.
- Defined:
  - Adds input IMMEDIATE (1 bit), sampled with the accept.
  - IMMEDIATE=1 loads FILL_FACTOR = clamped target at the accept edge and stays IDLE.
  - DONE pulses the following cycle; BUSY never asserts.
  - IMMEDIATE=0 behaves as normal.
- Undefined: IMMEDIATE port absent; every accepted target ramps.

Decomposition:
- Shared package/include pwm_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RAMP_UP=2'd1, ST_RAMP_DOWN=2'd2.
  - the fill-factor width expression $clog2(FILL_FACTOR_MAX), reused by the PWM channel.
- One sub-module: pwm_tick_div.
  - CE-qualified modulo-RAMP_DIV counter.
  - Inputs CLK, CLR, CE, SYNC_CLR; output TICK.
  - Reusable later for PWM prescaling.

Test Plan (MAX=7, STEP=1, RAMP_DIV=4, INIT_FILL=0, CE=1 unless stated):
- Reset: hold CLR=0 10 cycles, release → FILL_FACTOR=0, BUSY=0, DONE=0, TGT_READY=1 from the next cycle.
- Ramp up: accept TGT=3 at edge k → FILL_FACTOR=1,2,3 at edges k+4, k+8, k+12; BUSY=1 from k to k+12; DONE single pulse after k+12.
- Ramp down with STEP=2: from FILL_FACTOR=7 accept TGT=2 → 5, 3, 2 at k+4, k+8, k+12; no value below 2.
- CE gating: CE=0 for 6 cycles mid-ramp → FILL_FACTOR and cnt frozen; the remaining step schedule is delayed by exactly 6 cycles.
- Boundaries:
  - TGT_VALID during ramp → ignored, TGT_READY=0.
  - Accept TGT==FILL_FACTOR → DONE next cycle, BUSY stays 0.
  - With a wider TGT stimulus, TGT>7 → clamps to 7.
- Async reset mid-ramp at FILL_FACTOR=2 → immediate FILL_FACTOR=0, IDLE, no DONE.
- With PWM_FILL_RAMP_IMMEDIATE_EN: IMMEDIATE=1, TGT=6 → FILL_FACTOR=6 at the accept edge, DONE next cycle, BUSY=0.
